// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a FIFO of bytes feeding an LSB-first serializer.
// Frames chain back-to-back with no idle bit while the FIFO still holds data.
module uart_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_out
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is armed one clock before the final stop clock.
    localparam logic [CW-1:0] DONE_ARM  = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q, overflow_q;
    logic          push, pop, bit_end;

    state_t        state_q;
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q, busy_q, tx_done_q;

    assign bit_end = (baud_cnt_q == BAUD_LAST);
    assign push    = wr_en && !full_q;
    assign pop     = !empty_q && ((state_q == IDLE) || (state_q == STOP && bit_end));

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (!push && pop)
            count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + PTR_ONE;
            if (pop)
                rptr_q <= rptr_q + PTR_ONE;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            overflow_q <= wr_en && full_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (pop) begin
                        shift_q    <= mem_q[rptr_q];
                        baud_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= shift_q[0];
                        state_q    <= DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        shift_q    <= shift_q >> 1;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt_q == DONE_ARM)
                        tx_done_q <= 1'b1;
                    if (bit_end) begin
                        baud_cnt_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rptr_q];
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + BAUD_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;
    assign tx_out   = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: a default-baud instance (434 clocks/bit) and a
// 1 MHz / 9600 instance (104 clocks/bit); frames are checked clock by clock.
module tb_uart_tx;

    localparam int CPB_A = 434;
    localparam int CPB_B = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr_a = 1'b0, wr_b = 1'b0;
    logic       full_a, empty_a, ovf_a, busy_a, done_a, tx_a;
    logic       full_b, empty_b, ovf_b, busy_b, done_b, tx_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx dut_a (
        .clk(clk), .reset(rst_n), .data_in(data), .wr_en(wr_a),
        .full(full_a), .empty(empty_a), .overflow(ovf_a),
        .busy(busy_a), .tx_done(done_a), .tx_out(tx_a)
    );

    uart_tx #(.CLK_FREQ(1_000_000), .BAUD(9600), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(rst_n), .data_in(data), .wr_en(wr_b),
        .full(full_b), .empty(empty_b), .overflow(ovf_b),
        .busy(busy_b), .tx_done(done_b), .tx_out(tx_b)
    );

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;  // line order: bit 0 is the start bit
    } vec_t;

    function automatic logic line_of(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction
    function automatic logic done_of(input bit sel);
        return sel ? done_b : done_a;
    endfunction
    function automatic logic busy_of(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit sel, input logic [7:0] b);
        @(negedge clk);
        data = b;
        if (sel) wr_b = 1'b1; else wr_a = 1'b1;
        @(posedge clk);
        #1;
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    // Waits for the start bit, then checks every clock of the frame.
    // Returns at the negedge of the final stop-bit clock.
    task automatic capture(input bit sel, input logic [9:0] frame, input int cpb,
                           input int exp_gap, input string nm);
        int gap, done_err, busy_err, idx;
        bit found;
        int bit_err[10];
        gap = 0; found = 0; done_err = 0; busy_err = 0;
        foreach (bit_err[i]) bit_err[i] = 0;
        for (int i = 0; i < 20 * cpb && !found; i++) begin
            @(negedge clk);
            if (line_of(sel) === 1'b0) found = 1;
            else gap++;
        end
        chk({nm, " start seen"}, 32'(found), 32'd1);
        if (!found) return;
        chk({nm, " gap"}, gap, exp_gap);
        for (int k = 0; k < 10 * cpb; k++) begin
            if (k > 0) @(negedge clk);
            idx = k / cpb;
            if (line_of(sel) !== frame[idx]) bit_err[idx]++;
            if (done_of(sel) !== (k == 10 * cpb - 1)) done_err++;
            if (busy_of(sel) !== 1'b1) busy_err++;
        end
        for (int b = 0; b < 10; b++)
            chk($sformatf("%s bit%0d bad clocks", nm, b), bit_err[b], 0);
        chk({nm, " tx_done bad clocks"}, done_err, 0);
        chk({nm, " busy bad clocks"}, busy_err, 0);
    endtask

    task automatic idle_quiet(input bit sel, input int n, input string nm);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (line_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) errs++;
        end
        chk({nm, " idle bad clocks"}, errs, 0);
    endtask

    vec_t vecs[6];

    initial begin
        bit got;

        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'h81, 10'b1100000010};
        vecs[2] = '{8'hF0, 10'b1111100000};
        vecs[3] = '{8'h00, 10'b1000000000};
        vecs[4] = '{8'hFF, 10'b1111111110};
        vecs[5] = '{8'h3C, 10'b1001111000};

        repeat (3) @(negedge clk);
        chk("rst tx_a", tx_a, 1);       chk("rst busy_a", busy_a, 0);
        chk("rst done_a", done_a, 0);   chk("rst ovf_a", ovf_a, 0);
        chk("rst full_a", full_a, 0);   chk("rst empty_a", empty_a, 1);
        chk("rst tx_b", tx_b, 1);       chk("rst empty_b", empty_b, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Default baud: single byte, then two bytes written on consecutive clocks.
        push(0, 8'h55);
        chk("a wr empty", empty_a, 0);
        chk("a wr tx still idle", tx_a, 1);
        capture(0, 10'b1010101010, CPB_A, 1, "a 55");
        @(negedge clk);
        chk("a 55 busy after", busy_a, 0);
        chk("a 55 empty after", empty_a, 1);

        push(0, 8'hA5);
        push(0, 8'h3C);
        capture(0, 10'b1101001010, CPB_A, 0, "a A5");
        capture(0, 10'b1001111000, CPB_A, 0, "a 3C");
        @(negedge clk);
        chk("a b2b busy after", busy_a, 0);

        // 104 clocks/bit: vector table, one isolated frame each.
        foreach (vecs[i]) begin
            push(1, vecs[i].d);
            capture(1, vecs[i].frame, CPB_B, 1, $sformatf("b vec%0d", i));
        end

        // Overflow: fill the FIFO behind a running frame, then one extra write.
        push(1, 8'hAA);
        for (int i = 0; i < 16; i++) push(1, 8'(i));
        chk("ovf full after 16", full_b, 1);
        chk("ovf no pulse yet", ovf_b, 0);
        push(1, 8'h10);
        chk("ovf pulse", ovf_b, 1);
        chk("ovf full held", full_b, 1);
        @(posedge clk); #1;
        chk("ovf pulse one clock", ovf_b, 0);

        // Write on the very edge the next byte is popped while full.
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (done_b === 1'b1) got = 1;
        end
        chk("conc tx_done seen", 32'(got), 32'd1);
        data = 8'h77;
        wr_b = 1'b1;
        @(posedge clk); #1;
        wr_b = 1'b0;
        chk("conc ovf pulse", ovf_b, 1);
        chk("conc full cleared", full_b, 0);

        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    logic [7:0] b;
                    b = (i < 16) ? 8'(i) : 8'h99;
                    capture(1, {1'b1, b, 1'b0}, CPB_B, 0, $sformatf("b fifo%0d", i));
                end
            end
            begin
                push(1, 8'h99);
                chk("conc later write full", full_b, 1);
                chk("conc later write no ovf", ovf_b, 0);
            end
        join
        idle_quiet(1, 1500, "b after drain");
        chk("b drain empty", empty_b, 1);

        // Asynchronous reset in the middle of data bit 3 of 0xF0.
        push(1, 8'hF0);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (tx_b === 1'b0) got = 1;
        end
        chk("rstmid start seen", 32'(got), 32'd1);
        repeat (4 * CPB_B + 50) @(negedge clk);
        chk("rstmid bit3 low", tx_b, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid tx", tx_b, 1);
        chk("rstmid busy", busy_b, 0);
        chk("rstmid empty", empty_b, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_quiet(1, 1500, "b after reset");
        chk("rstmid empty after", empty_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
